// File: rtl/led_pkg.sv
// Shared types and constants for the LED scanner: run modes, the
// direction state encoding and the pattern loaded on reset or recovery.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE    = 2'b00,
    MODE_ROT_LEFT  = 2'b01,
    MODE_ROT_RIGHT = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_t;

  typedef enum logic {
    S_LEFT  = 1'b0,
    S_RIGHT = 1'b1
  } dir_t;

  localparam int unsigned LED_RESET_PATTERN = 1;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: emits a one-cycle tick every step_div+1 enabled
// cycles; freezes while enable is low.
module led_prescaler #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // >= rather than == so lowering step_div below the count ticks at once
  always_comb begin
    tick    = 1'b0;
    count_d = count_q;
    if (enable) begin
      if (count_q >= step_div) begin
        tick    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/led_scanner.sv
// One-hot LED scanner: bounces or rotates a single lit LED across WIDTH
// outputs, one step per prescaler tick, with a pulse on each end event.
module led_scanner
  import led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] step_div,
  output logic [WIDTH-1:0]     led_out,
  output logic                 dir_out,
  output logic                 end_pulse
);

  logic             tick;
  dir_t             state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             end_q, end_d;

  led_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .step_div (step_div),
    .tick     (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LEFT;
      led_q   <= WIDTH'(LED_RESET_PATTERN);
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    end_d   = 1'b0;
    if (tick) begin
      // A corrupted pattern is repaired in every mode, HOLD included
      if (!$onehot(led_q)) begin
        led_d   = WIDTH'(LED_RESET_PATTERN);
        state_d = S_LEFT;
      end else begin
        case (mode_t'(mode))
          MODE_BOUNCE: begin
            if (state_q == S_LEFT) begin
              if (led_q[WIDTH-1]) begin
                state_d = S_RIGHT;
                led_d   = led_q >> 1;
                end_d   = 1'b1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                state_d = S_LEFT;
                led_d   = led_q << 1;
                end_d   = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_ROT_LEFT: begin
            state_d = S_LEFT;
            led_d   = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            end_d   = led_q[WIDTH-1];
          end
          MODE_ROT_RIGHT: begin
            state_d = S_RIGHT;
            led_d   = {led_q[0], led_q[WIDTH-1:1]};
            end_d   = led_q[0];
          end
          default: begin
            state_d = state_q;
            led_d   = led_q;
          end
        endcase
      end
    end
  end

  always_comb begin
    led_out   = led_q;
    dir_out   = (state_q == S_RIGHT);
    end_pulse = end_q;
  end

endmodule

// File: tb/tb_led_scanner.sv
// Self-checking bench for led_scanner (WIDTH=4): directed vector table,
// hand-written corner sequences and randomized runs against a position model.
module tb_led_scanner;
  import led_pkg::*;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] step_div;
  logic [W-1:0]  led_out;
  logic          dir_out;
  logic          end_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model: lit LED index, direction, prescaler count, end flag
  int m_pos, m_dir, m_cnt, m_end;

  led_scanner #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .step_div  (step_div),
    .led_out   (led_out),
    .dir_out   (dir_out),
    .end_pulse (end_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] led;
    logic         dir;
    logic         endp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_cnt = 0; m_end = 0;
  endtask

  task automatic model_edge();
    bit tk;
    tk = 0;
    m_end = 0;
    if (enable) begin
      if (m_cnt >= int'(step_div)) begin
        tk = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (tk) begin
      case (mode)
        2'b00: begin
          if (m_dir == 0) begin
            if (m_pos == W - 1) begin m_dir = 1; m_pos--; m_end = 1; end
            else m_pos++;
          end else begin
            if (m_pos == 0) begin m_dir = 0; m_pos++; m_end = 1; end
            else m_pos--;
          end
        end
        2'b01: begin m_dir = 0; m_end = (m_pos == W - 1); m_pos = (m_pos + 1) % W; end
        2'b10: begin m_dir = 1; m_end = (m_pos == 0); m_pos = (m_pos + W - 1) % W; end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_led"}, 32'(led_out), 32'(1 << m_pos));
    check({tag, "_dir"}, 32'(dir_out), 32'(m_dir));
    check({tag, "_end"}, 32'(end_pulse), 32'(m_end));
  endtask

  // One clock edge: advance model, then compare just after the edge
  task automatic cycle(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[16];
    logic [W-1:0] held;

    vecs[0]  = '{2'b00, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 4'b0100, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 4'b1000, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 4'b0100, 1'b1, 1'b1};
    vecs[4]  = '{2'b00, 4'b0010, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 4'b0001, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 4'b0010, 1'b0, 1'b1};
    vecs[7]  = '{2'b00, 4'b0100, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 4'b1000, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 4'b0001, 1'b0, 1'b1};
    vecs[10] = '{2'b01, 4'b0010, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 4'b0001, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 4'b1000, 1'b1, 1'b1};
    vecs[13] = '{2'b10, 4'b0100, 1'b1, 1'b0};
    vecs[14] = '{2'b11, 4'b0100, 1'b1, 1'b0};
    vecs[15] = '{2'b11, 4'b0100, 1'b1, 1'b0};

    reset = 1'b1; enable = 1'b0; mode = 2'b00; step_div = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_led", 32'(led_out), 32'h1);
    check("reset_dir", 32'(dir_out), 32'h0);
    check("reset_end", 32'(end_pulse), 32'h0);
    reset = 1'b0;

    // Directed table: step_div=0, one step per edge
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].mode;
      cycle("tbl");
      check("tbl_vec_led", 32'(led_out), 32'(vecs[i].led));
      check("tbl_vec_dir", 32'(dir_out), 32'(vecs[i].dir));
      check("tbl_vec_end", 32'(end_pulse), 32'(vecs[i].endp));
      $display("vec %0d mode=%0d led=%b dir=%0d end=%0d", i, mode, led_out, dir_out, end_pulse);
    end

    // step_div=2: a change every third edge; then shrink step_div at count 2
    mode = 2'b00; step_div = 8'd2;
    do_reset();
    for (int i = 0; i < 9; i++) cycle("div2");
    do_reset();
    cycle("shrink"); cycle("shrink");
    step_div = 8'd1;
    cycle("shrink");
    check("shrink_tick", 32'(led_out), 32'h2);
    $display("step_div shrink led=%b", led_out);

    // Freeze mid-count with enable low, then resume
    step_div = 8'd4;
    cycle("frz"); cycle("frz");
    held = led_out;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) cycle("frz");
    check("frz_held", 32'(led_out), 32'(held));
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle("frz");
    $display("freeze resume led=%b", led_out);

    // HOLD for 10 ticks
    mode = 2'b11; step_div = '0;
    held = led_out;
    for (int i = 0; i < 10; i++) begin
      cycle("hold");
      check("hold_end", 32'(end_pulse), 32'h0);
    end
    check("hold_led", 32'(led_out), 32'(held));
    $display("hold led=%b", led_out);

    // Asynchronous reset between edges, then first step on 4th edge
    mode = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) cycle("pre_ar");
    check("pre_ar_led", 32'(led_out), 32'h4);
    check("pre_ar_dir", 32'(dir_out), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_led", 32'(led_out), 32'h1);
    check("async_dir", 32'(dir_out), 32'h0);
    model_reset();
    #1 reset = 1'b0;
    step_div = 8'd3;
    for (int i = 0; i < 3; i++) cycle("post_ar");
    check("post_ar_wait", 32'(led_out), 32'h1);
    cycle("post_ar");
    check("post_ar_step", 32'(led_out), 32'h2);
    $display("async reset recovered led=%b", led_out);

    // Corrupted pattern repaired on the next tick (HOLD keeps the rest still)
    step_div = '0; mode = 2'b10;
    cycle("pre_seu");
    mode = 2'b11;
    @(negedge clock);
    force dut.led_q = 4'b0110;
    @(posedge clock);
    #1 release dut.led_q;
    @(posedge clock);
    #1;
    check("seu_led", 32'(led_out), 32'h1);
    check("seu_dir", 32'(dir_out), 32'h0);
    check("seu_end", 32'(end_pulse), 32'h0);
    model_reset();
    $display("seu recovery led=%b dir=%0d", led_out, dir_out);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      if (i % 17 == 0) begin
        mode = 2'($urandom_range(0, 3));
        step_div = DW'($urandom_range(0, 3));
      end
      enable = ($urandom_range(0, 9) != 0);
      cycle("rnd");
    end
    $display("random run done led=%b", led_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scanner.md
Name: led_scanner

Overview:
Parametrised successor to the single-direction LED shifter: drives a one-hot LED pattern of configurable width that bounces end to end or rotates in either direction. An on-board prescaler paces the steps. Run/hold control and per-step status pulses are provided. Sits between board clock/reset and the LED pins, and feeds the status/debug logic.

Parameters:
WIDTH, 8, number of LEDs (pattern bits); must be >= 2
DIV_WIDTH, 24, width of the prescaler counter and of step_div

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = run; 0 = freeze prescaler and pattern
mode  input  2  00 BOUNCE, 01 ROT_LEFT, 10 ROT_RIGHT, 11 HOLD
step_div  input  DIV_WIDTH  step period minus 1, in clock cycles
led_out  output  WIDTH  registered one-hot LED pattern
dir_out  output  1  current direction: 0 = left (towards MSB), 1 = right
end_pulse  output  1  one-cycle pulse on a bounce reversal or rotate wrap

Behaviour:
- Reset (async, any time, including mid-step):
  - led_out = 1 (bit 0 lit), dir state = S_LEFT, dir_out = 0
  - prescaler count = 0, end_pulse = 0
  - On release, the first tick occurs after step_div+1 enabled cycles.
- Prescaler:
  - When enable = 1: if count >= step_div, then tick = 1 and count <= 0; else count <= count+1.
  - Using >= makes a step_div reduction below the current count tick on the next cycle; there is no wrap-around wait.
  - step_div = 0 gives a tick every cycle.
  - When enable = 0: count holds, tick = 0.
- Pattern update: on a tick only, registered, so led_out changes on the clock edge where tick is high (1-cycle latency from tick).
- Direction FSM, states S_LEFT and S_RIGHT; dir_out = (state == S_RIGHT).
- BOUNCE:
  - S_LEFT, led_out[WIDTH-1] = 0: shift left.
  - S_LEFT, led_out[WIDTH-1] = 1: go to S_RIGHT, shift right, end_pulse = 1.
  - S_RIGHT is symmetric, reversing at bit 0.
  - The end LEDs are lit for exactly one step (no double dwell).
- ROT_LEFT:
  - State forced to S_LEFT on the tick.
  - Rotate left; MSB wraps to bit 0 with end_pulse = 1.
- ROT_RIGHT:
  - State forced to S_RIGHT on the tick.
  - Rotate right; bit 0 wraps to MSB with end_pulse = 1.
- HOLD:
  - Prescaler keeps running, but ticks are ignored.
  - Pattern, state and end_pulse (0) are held.
- Mode changes are sampled only at a tick. Mid-step changes take effect at the next tick, from the current position.
- end_pulse is registered, high for exactly the cycle after the updating edge, and 0 otherwise.
- Invariant: led_out is always one-hot. If a non-one-hot value is detected (e.g. after an SEU), the next tick reloads 1 and sets state S_LEFT.
- Simultaneous enable = 0 and count >= step_div: no tick.

Decomposition:
- Shared package led_pkg:
  - mode_t enum (MODE_BOUNCE = 2'b00, MODE_ROT_LEFT, MODE_ROT_RIGHT, MODE_HOLD)
  - dir_t enum (S_LEFT, S_RIGHT)
  - constant LED_RESET_PATTERN = 1
- One sub-module, led_prescaler (params DIV_WIDTH):
  - inputs: clock, reset, enable, step_div
  - output: tick
- The top module holds the FSM and pattern register.

Test Plan:
- WIDTH=4, step_div=0, BOUNCE, enable=1 after reset → led_out sequence:
  - 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010
  - end_pulse high on the cycles showing the first 0100 after 1000 and the 0010 after 0001
  - dir_out = 1 from the first 0100 through 0001
- WIDTH=4, ROT_LEFT, step_div=0 → 0001, 0010, 0100, 1000, 0001, with end_pulse at the 0001 wrap; then ROT_RIGHT → 1000 after 0001, with end_pulse and dir_out = 1.
- step_div=2 → led_out changes exactly every 3 cycles. With the count at 2 and step_div changed to 1, the next cycle ticks.
- Enable held low for 5 cycles mid-count → led_out and count frozen; the step resumes with the remaining count. HOLD mode for 10 ticks → led_out unchanged, end_pulse = 0.
- Assert reset asynchronously between edges with led_out = 0100, dir right → led_out = 0001 and dir_out = 0 immediately, without a clock. After release with step_div=3, the first change comes on the 4th enabled edge.
- Force led_out = 0000 (or 0110) via the bench → the next tick restores 0001, S_LEFT.
